// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: single-access sequencer for the 128x128 6T bit-cell array.
// It turns one req/ready word request into array timing: bitline precharge,
// one-hot wordline, write_en / sense_en and column select. It also captures
// the sense-amp output into rdata.
//
// Optional feature: define SRAM_ACCESS_PARITY_EN to widen the array data path
// to DW+1 bits, with an even-parity bit on writes and a parity check on reads.
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   req, we        request strobe and direction (1 = write), sampled when ready
//   addr           {row, column word}
//   wdata          write data, sampled with req
//   ready          controller idle; accepts on an edge with req && ready
//   rdata, rvalid  registered read data and its one-cycle valid pulse
//   perr           read parity error, valid with rvalid (0 without parity)
//   wl             one-hot wordline
//   col_sel        one-hot column mux select
//   precharge_n    active-low bitline precharge
//   write_en       global write enable
//   sense_en       sense-amp latch enable
//   bl_wdata       write-driver data
//   sa_data        sense-amp outputs
module sram_access_ctrl #(
  parameter int unsigned ROWS       = 128,
  parameter int unsigned COL_MUX    = 4,
  parameter int unsigned DW         = 32,
  parameter int unsigned PRE_CYCLES = 2,
  parameter int unsigned DEV_CYCLES = 2,
  parameter int unsigned WR_CYCLES  = 2,
  localparam int unsigned ROW_W = $clog2(ROWS),
  localparam int unsigned COL_W = $clog2(COL_MUX),
  localparam int unsigned AW    = ROW_W + COL_W,
`ifdef SRAM_ACCESS_PARITY_EN
  localparam int unsigned DWP   = DW + 1
`else
  localparam int unsigned DWP   = DW
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [DW-1:0]      wdata,
  output logic               ready,
  output logic [DWP-1:0]     rdata,
  output logic               rvalid,
  output logic               perr,
  output logic [ROWS-1:0]    wl,
  output logic [COL_MUX-1:0] col_sel,
  output logic               precharge_n,
  output logic               write_en,
  output logic               sense_en,
  output logic [DWP-1:0]     bl_wdata,
  input  logic [DWP-1:0]     sa_data
);

  localparam int unsigned MAX_PD = (PRE_CYCLES > DEV_CYCLES) ? PRE_CYCLES : DEV_CYCLES;
  localparam int unsigned MAX_P  = (MAX_PD > WR_CYCLES) ? MAX_PD : WR_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    IDLE, PRE, ACT, SENSE, WRITE, RECOVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [ROW_W-1:0] row_q;
  logic             we_q;
  logic [ROWS-1:0]  wl_row;
  logic [DWP-1:0]   wdata_ext;

  // Wordline decode of the latched row.
  assign wl_row = ROWS'(1) << row_q;

  // Write-driver data, with the parity bit appended when enabled.
`ifdef SRAM_ACCESS_PARITY_EN
  assign wdata_ext = {^wdata, wdata};
`else
  assign wdata_ext = wdata;
`endif

  // Sequencer: the phase counter reloads on every state entry and the state
  // exits when it reaches zero. All array controls are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      row_q       <= '0;
      we_q        <= 1'b0;
      ready       <= 1'b1;
      precharge_n <= 1'b0;
      wl          <= '0;
      col_sel     <= '0;
      write_en    <= 1'b0;
      sense_en    <= 1'b0;
      rvalid      <= 1'b0;
      rdata       <= '0;
      bl_wdata    <= '0;
    end else begin
      rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (req && ready) begin
            row_q    <= addr[AW-1:COL_W];
            we_q     <= we;
            col_sel  <= COL_MUX'(1) << addr[COL_W-1:0];
            bl_wdata <= wdata_ext;
            ready    <= 1'b0;
            cnt      <= CNT_W'(PRE_CYCLES - 1);
            state    <= PRE;
          end
        end
        PRE: begin
          if (cnt == '0) begin
            precharge_n <= 1'b1;
            wl          <= wl_row;
            if (we_q) begin
              write_en <= 1'b1;
              cnt      <= CNT_W'(WR_CYCLES - 1);
              state    <= WRITE;
            end else begin
              cnt   <= CNT_W'(DEV_CYCLES - 1);
              state <= ACT;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACT: begin
          if (cnt == '0) begin
            sense_en <= 1'b1;
            cnt      <= '0;
            state    <= SENSE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SENSE: begin
          rdata       <= sa_data;
          rvalid      <= 1'b1;
          sense_en    <= 1'b0;
          wl          <= '0;
          precharge_n <= 1'b0;
          cnt         <= '0;
          state       <= RECOVER;
        end
        WRITE: begin
          if (cnt == '0) begin
            write_en    <= 1'b0;
            wl          <= '0;
            precharge_n <= 1'b0;
            cnt         <= '0;
            state       <= RECOVER;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RECOVER: begin
          col_sel <= '0;
          ready   <= 1'b1;
          cnt     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Parity check is registered alongside rdata on the SENSE exit edge.
`ifdef SRAM_ACCESS_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr <= 1'b0;
    end else if (state == SENSE) begin
      perr <= ^sa_data;
    end
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: self-checking bench for sram_access_ctrl.
// It contains a behavioural bit-cell array driven by wl/col_sel/write_en,
// a table of accesses with per-cycle phase checks, a read-data scoreboard,
// and hand-written reset-mid-op and parity sequences.
module tb_sram_access_ctrl;

  localparam int unsigned ROWS    = 128;
  localparam int unsigned COL_MUX = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned COL_W   = 2;
  localparam int unsigned AW      = 9;
  localparam int P  = 2;
  localparam int D  = 2;
  localparam int WR = 2;
  localparam int PH_W = 5 + COL_MUX + ROWS;
`ifdef SRAM_ACCESS_PARITY_EN
  localparam int unsigned DWP = DW + 1;
`else
  localparam int unsigned DWP = DW;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req = 1'b0;
  logic               we = 1'b0;
  logic [AW-1:0]      addr = '0;
  logic [DW-1:0]      wdata = '0;
  logic               ready;
  logic [DWP-1:0]     rdata;
  logic               rvalid;
  logic               perr;
  logic [ROWS-1:0]    wl;
  logic [COL_MUX-1:0] col_sel;
  logic               precharge_n;
  logic               write_en;
  logic               sense_en;
  logic [DWP-1:0]     bl_wdata;
  logic [DWP-1:0]     sa_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_access_ctrl #(
    .ROWS(ROWS), .COL_MUX(COL_MUX), .DW(DW),
    .PRE_CYCLES(P), .DEV_CYCLES(D), .WR_CYCLES(WR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rvalid(rvalid), .perr(perr), .wl(wl),
    .col_sel(col_sel), .precharge_n(precharge_n), .write_en(write_en),
    .sense_en(sense_en), .bl_wdata(bl_wdata), .sa_data(sa_data)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Behavioural bit-cell array.
  logic [DWP-1:0] cell_mem [ROWS*COL_MUX];
  logic [DWP-1:0] flip = '0;

  function automatic int unsigned oh_idx(input logic [ROWS-1:0] v);
    for (int i = 0; i < int'(ROWS); i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk)
    if (write_en) cell_mem[oh_idx(wl) * COL_MUX + oh_idx(ROWS'(col_sel))] <= bl_wdata;

  always_comb
    sa_data = (wl != '0) ? (cell_mem[oh_idx(wl) * COL_MUX + oh_idx(ROWS'(col_sel))] ^ flip) : '0;

  // Read scoreboard.
  typedef struct packed { logic [DWP-1:0] data; logic perr; } exp_t;
  exp_t sb[$];
  exp_t sb_e;

  always @(negedge clk) begin
    if (rvalid) begin
      if (sb.size() == 0) chk("unexpected_rvalid", 1, 0);
      else begin
        sb_e = sb.pop_front();
        chk("rdata", rdata, sb_e.data);
        chk("perr", perr, sb_e.perr);
      end
    end
  end

  // Array-safety invariants, one comparison per cycle.
  always @(negedge clk)
    chk("invariants", {!$onehot0(wl), (wl != '0) && !precharge_n,
                       write_en && sense_en, rvalid && ready}, 4'b0000);

  function automatic logic [DWP-1:0] ext(input logic [DW-1:0] d);
`ifdef SRAM_ACCESS_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Expected {ready, precharge_n, write_en, sense_en, rvalid, col_sel, wl}
  // after edge k, with k = 0 the acceptance edge.
  function automatic logic [PH_W-1:0] exp_phase(input logic w, input logic [AW-1:0] a, input int k);
    logic rdy = 1'b0, pn = 1'b0, wen = 1'b0, se = 1'b0, rv = 1'b0;
    logic [ROWS-1:0]    one_r = 1;
    logic [COL_MUX-1:0] one_c = 1;
    logic [ROWS-1:0]    wlv = '0;
    logic [COL_MUX-1:0] cs;
    int last;
    cs   = one_c << a[COL_W-1:0];
    last = w ? P + WR + 1 : P + D + 2;
    if (k < P) begin
    end else if (k == last) begin
      rdy = 1'b1;
      cs  = '0;
    end else if (k == last - 1) begin
      rv = !w;
    end else begin
      pn  = 1'b1;
      wlv = one_r << a[AW-1:COL_W];
      if (w) wen = 1'b1;
      else if (k == P + D) se = 1'b1;
    end
    return {rdy, pn, wen, se, rv, cs, wlv};
  endfunction

  // One access; call at a falling edge. hold keeps req high afterwards,
  // noise drives random ignored requests while busy.
  task automatic do_access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DWP-1:0] exp_d, input logic exp_perr,
                           input bit hold, input bit noise, input string tag);
    int waited = 0;
    int last;
    exp_t e;
    while (!ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ready_wait"}, ready, 1);
    if (!ready) return;
    req = 1'b1; we = w; addr = a; wdata = d;
    if (!w) begin
      e.data = exp_d;
      e.perr = exp_perr;
      sb.push_back(e);
    end
    @(posedge clk);
    last = w ? P + WR + 1 : P + D + 2;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      chk($sformatf("%s_k%0d", tag, k),
          {ready, precharge_n, write_en, sense_en, rvalid, col_sel, wl}, exp_phase(w, a, k));
      if (!hold) begin
        if (noise && k < last) begin
          req   = 1'($urandom_range(0, 1));
          we    = 1'($urandom);
          addr  = AW'($urandom);
          wdata = $urandom;
        end else begin
          req = 1'b0;
        end
      end
    end
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    bit            hold;
    bit            noise;
  } vec_t;
  vec_t vecs[9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 9'h1A5, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
    vecs[1] = '{1'b0, 9'h1A5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 9'h000, 32'h12345678, 32'h0,        1'b0, 1'b0};
    vecs[3] = '{1'b1, 9'h1FF, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b1};
    vecs[4] = '{1'b1, 9'h1A4, 32'h0BADF00D, 32'h0,        1'b0, 1'b0};
    vecs[5] = '{1'b0, 9'h1FF, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 9'h1A4, 32'h0,        32'h0BADF00D, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 9'h1A5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 9'h000, 32'h0,        32'h12345678, 1'b0, 1'b0};

    // Reset, then idle with no access.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_precharge_n", precharge_n, 0);
    chk("rst_wl", wl, 0);
    chk("rst_col_sel", col_sel, 0);
    chk("rst_en", {write_en, sense_en, rvalid, perr}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bl_wdata", bl_wdata, 0);

    // Table of accesses.
    for (int i = 0; i < 9; i++)
      do_access(vecs[i].w, vecs[i].a, vecs[i].d, ext(vecs[i].exp), 1'b0,
                vecs[i].hold, vecs[i].noise, $sformatf("v%0d", i));

    // Reset during ACT of a read: everything drops at once, no rvalid.
    req = 1'b1; we = 1'b0; addr = 9'h000;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (P) @(negedge clk);
    chk("mid_in_act", wl, ROWS'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wl", wl, 0);
    chk("mid_rst_precharge_n", precharge_n, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_en", {write_en, sense_en, rvalid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(1'b0, 9'h000, 32'h0, ext(32'h12345678), 1'b0, 1'b0, 1'b0, "after_rst");

`ifdef SRAM_ACCESS_PARITY_EN
    // Parity: stored {1, 32'h1}; flipping the parity bit must raise perr.
    do_access(1'b1, 9'h0C3, 32'h00000001, '0, 1'b0, 1'b0, 1'b0, "par_wr");
    flip = DWP'(1) << DW;
    do_access(1'b0, 9'h0C3, 32'h0, {1'b0, 32'h00000001}, 1'b1, 1'b0, 1'b0, "par_flip");
    flip = '0;
    do_access(1'b0, 9'h0C3, 32'h0, {1'b1, 32'h00000001}, 1'b0, 1'b0, 1'b0, "par_ok");
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
